// File: rtl/vga_timing_generator.sv
// VGA horizontal/vertical timing generator with a pixel-tick divider,
// integer pixel scaling, registered sync/enable outputs and line/frame strobes.
module vga_timing_generator #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned H_SCALE  = 5,
    parameter int unsigned V_SCALE  = 5,
    parameter int unsigned HPIX_W   = 8,
    parameter int unsigned VPIX_W   = 7,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              hsync,
    output logic              vsync,
    output logic [HPIX_W-1:0] hpixel,
    output logic [VPIX_W-1:0] vpixel,
    output logic              display_en,
    output logic              line_start,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HC_W  = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VC_W  = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_W  = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int unsigned VS_W  = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_ACT_C    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]  H_ACT_LAST = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0]  H_SYNC_S   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]  H_SYNC_E   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_ACT_C    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]  V_ACT_LAST = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0]  V_SYNC_S   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]  V_SYNC_E   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [HS_W-1:0]  HSUB_LAST  = HS_W'(H_SCALE - 1);
    localparam logic [VS_W-1:0]  VSUB_LAST  = VS_W'(V_SCALE - 1);

    logic [DIV_W-1:0]  r_div;
    logic [HC_W-1:0]   r_hcnt;
    logic [VC_W-1:0]   r_vcnt;
    logic [HS_W-1:0]   r_hsub;
    logic [VS_W-1:0]   r_vsub;
    logic [HPIX_W-1:0] r_hpix;
    logic [VPIX_W-1:0] r_vpix;
    logic              r_pos_new;

    logic              r_hsync;
    logic              r_vsync;
    logic [HPIX_W-1:0] r_hpixel;
    logic [VPIX_W-1:0] r_vpixel;
    logic              r_display_en;
    logic              r_line_start;
    logic              r_frame_start;

    logic w_tick;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_act;
    logic w_v_act;
    logic w_h_sync;
    logic w_v_sync;
    logic w_line_start;

    // Pixel tick, wrap conditions and region decode of the current counters
    always_comb begin
        w_tick       = enable & (r_div == DIV_LAST);
        w_h_wrap     = w_tick & (r_hcnt == H_LAST);
        w_v_wrap     = w_h_wrap & (r_vcnt == V_LAST);
        w_h_act      = (r_hcnt < H_ACT_C);
        w_v_act      = (r_vcnt < V_ACT_C);
        w_h_sync     = (r_hcnt >= H_SYNC_S) && (r_hcnt < H_SYNC_E);
        w_v_sync     = (r_vcnt >= V_SYNC_S) && (r_vcnt < V_SYNC_E);
        w_line_start = r_pos_new & (r_hcnt == '0);
    end

    // Clock divider, raster position counters and new-position flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_pos_new <= 1'b1;
        end else if (enable) begin
            r_pos_new <= w_tick;
            if (w_tick) begin
                r_div  <= '0;
                r_hcnt <= w_h_wrap ? '0 : r_hcnt + 1'b1;
                if (w_h_wrap) begin
                    r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Horizontal scaling: hpix steps once per H_SCALE active ticks.
    // The step on the last active pixel is suppressed so hpix never
    // passes H_ACTIVE/H_SCALE-1 while the blanking interval runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsub <= '0;
            r_hpix <= '0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_hsub <= '0;
                r_hpix <= '0;
            end else if (w_h_act) begin
                if (r_hsub == HSUB_LAST) begin
                    r_hsub <= '0;
                    if (r_hcnt != H_ACT_LAST) begin
                        r_hpix <= r_hpix + 1'b1;
                    end
                end else begin
                    r_hsub <= r_hsub + 1'b1;
                end
            end
        end
    end

    // Vertical scaling: vpix steps once per V_SCALE active lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsub <= '0;
            r_vpix <= '0;
        end else if (w_h_wrap) begin
            if (w_v_wrap) begin
                r_vsub <= '0;
                r_vpix <= '0;
            end else if (w_v_act) begin
                if (r_vsub == VSUB_LAST) begin
                    r_vsub <= '0;
                    if (r_vcnt != V_ACT_LAST) begin
                        r_vpix <= r_vpix + 1'b1;
                    end
                end else begin
                    r_vsub <= r_vsub + 1'b1;
                end
            end
        end
    end

    // Registered output decode, idle values during reset or freeze
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_hpixel      <= '0;
            r_vpixel      <= '0;
            r_display_en  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            r_display_en  <= w_h_act & w_v_act;
            r_hpixel      <= (w_h_act & w_v_act) ? r_hpix : '0;
            r_vpixel      <= (w_h_act & w_v_act) ? r_vpix : '0;
            r_line_start  <= w_line_start;
            r_frame_start <= w_line_start & (r_vcnt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hpixel      = r_hpixel;
    assign vpixel      = r_vpixel;
    assign display_en  = r_display_en;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator: three geometries (default,
// fast unscaled active-high, tiny) driven together and compared every clock
// against an arithmetic raster model indexed by the enabled-clock count.
module tb_vga_timing_generator;

    typedef struct packed {
        int unsigned div;
        int unsigned ha, hfp, hsw, hbp;
        int unsigned va, vfp, vsw, vbp;
        int unsigned hsc, vsc;
        bit          pol;
    } geom_t;

    typedef struct packed {
        logic        hs, vs, de, ls, fs;
        logic [15:0] hp, vp;
    } vout_t;

    localparam geom_t G_DEF = '{div: 4, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                                va: 480, vfp: 10, vsw: 2, vbp: 33,
                                hsc: 5, vsc: 5, pol: 1'b0};
    localparam geom_t G_ALT = '{div: 1, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                                va: 480, vfp: 10, vsw: 2, vbp: 33,
                                hsc: 1, vsc: 1, pol: 1'b1};
    localparam geom_t G_SML = '{div: 2, ha: 12, hfp: 2, hsw: 3, hbp: 3,
                                va: 6, vfp: 1, vsw: 2, vbp: 1,
                                hsc: 3, vsc: 2, pol: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic       d_hsync, d_vsync, d_de, d_ls, d_fs;
    logic [7:0] d_hp;
    logic [6:0] d_vp;
    logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
    logic [9:0] a_hp;
    logic [8:0] a_vp;
    logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [1:0] s_hp;
    logic [1:0] s_vp;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned n = 0;
    int unsigned exp_n = 0;
    bit          exp_act = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    vga_timing_generator u_def (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(d_hsync), .vsync(d_vsync), .hpixel(d_hp), .vpixel(d_vp),
        .display_en(d_de), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_generator #(
        .CLK_DIV(1), .H_SCALE(1), .V_SCALE(1),
        .HPIX_W(10), .VPIX_W(9), .SYNC_POL(1'b1)
    ) u_alt (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(a_hsync), .vsync(a_vsync), .hpixel(a_hp), .vpixel(a_vp),
        .display_en(a_de), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_generator #(
        .CLK_DIV(2), .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SCALE(3), .V_SCALE(2), .HPIX_W(2), .VPIX_W(2), .SYNC_POL(1'b0)
    ) u_sml (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(s_hsync), .vsync(s_vsync), .hpixel(s_hp), .vpixel(s_vp),
        .display_en(s_de), .line_start(s_ls), .frame_start(s_fs)
    );

    // Expected outputs after an edge that was the (n+1)-th enabled clock since reset
    function automatic vout_t ref_out(geom_t g, int unsigned cnt, bit active);
        vout_t o;
        int unsigned ht, vt, p, h, v;
        bit pn;
        o = '{hs: ~g.pol, vs: ~g.pol, de: 1'b0, ls: 1'b0, fs: 1'b0, hp: 16'd0, vp: 16'd0};
        if (!active) return o;
        ht = g.ha + g.hfp + g.hsw + g.hbp;
        vt = g.va + g.vfp + g.vsw + g.vbp;
        p  = (cnt / g.div) % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        pn = (cnt % g.div) == 0;
        if (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw) o.hs = g.pol;
        if (v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw) o.vs = g.pol;
        if (h < g.ha && v < g.va) begin
            o.de = 1'b1;
            o.hp = 16'(h / g.hsc);
            o.vp = 16'(v / g.vsc);
        end
        o.ls = pn && (h == 0);
        o.fs = o.ls && (v == 0);
        return o;
    endfunction

    function automatic logic [3*$bits(vout_t)-1:0] observed();
        vout_t d, a, s;
        d = '{hs: d_hsync, vs: d_vsync, de: d_de, ls: d_ls, fs: d_fs, hp: 16'(d_hp), vp: 16'(d_vp)};
        a = '{hs: a_hsync, vs: a_vsync, de: a_de, ls: a_ls, fs: a_fs, hp: 16'(a_hp), vp: 16'(a_vp)};
        s = '{hs: s_hsync, vs: s_vsync, de: s_de, ls: s_ls, fs: s_fs, hp: 16'(s_hp), vp: 16'(s_vp)};
        return {d, a, s};
    endfunction

    function automatic logic [3*$bits(vout_t)-1:0] predicted();
        return {ref_out(G_DEF, exp_n, exp_act), ref_out(G_ALT, exp_n, exp_act),
                ref_out(G_SML, exp_n, exp_act)};
    endfunction

    // Apply inputs for one edge, advance the model, settle past the edge
    task automatic step(input bit r, input bit e);
        reset  = r;
        enable = e;
        @(posedge clk);
        cyc++;
        if (r) begin
            n = 0;
            exp_act = 1'b0;
        end else if (e) begin
            exp_n = n;
            n++;
            exp_act = 1'b1;
        end else begin
            exp_act = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
        end
    endtask

    task automatic test_first_lines();
        int unsigned de_cnt = 0, hs_low = 0, ls_cnt = 0, hp_max = 0, a_hs_hi = 0, a_hp_max = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 6500; i++) begin
            step(1'b0, 1'b1);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL first_lines cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
            if (i < 3200) begin
                if (d_de) de_cnt++;
                if (!d_hsync) hs_low++;
                if (d_ls) ls_cnt++;
                if (int'(d_hp) > hp_max) hp_max = d_hp;
            end
            if (i < 800) begin
                if (a_hsync) a_hs_hi++;
                if (int'(a_hp) > a_hp_max) a_hp_max = a_hp;
            end
        end
        tests_run++;
        if (de_cnt != 2560) begin
            tests_failed++;
            $display("FAIL line_de_clocks got=%0d exp=2560", de_cnt);
        end
        tests_run++;
        if (hs_low != 384) begin
            tests_failed++;
            $display("FAIL line_hsync_clocks got=%0d exp=384", hs_low);
        end
        tests_run++;
        if (ls_cnt != 1) begin
            tests_failed++;
            $display("FAIL line_start_count got=%0d exp=1", ls_cnt);
        end
        tests_run++;
        if (hp_max != 127) begin
            tests_failed++;
            $display("FAIL hpixel_peak got=%0d exp=127", hp_max);
        end
        tests_run++;
        if (a_hs_hi != 96) begin
            tests_failed++;
            $display("FAIL alt_hsync_high got=%0d exp=96", a_hs_hi);
        end
        tests_run++;
        if (a_hp_max != 639) begin
            tests_failed++;
            $display("FAIL alt_hpixel_peak got=%0d exp=639", a_hp_max);
        end
    endtask

    task automatic test_frame_small();
        int unsigned fs_cnt = 0, ls_cnt = 0, vs_low = 0, de_cnt = 0, hp_max = 0, vp_max = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'b1);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL frame_small cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
            if (s_fs) fs_cnt++;
            if (s_ls) ls_cnt++;
            if (!s_vsync) vs_low++;
            if (s_de) de_cnt++;
            if (int'(s_hp) > hp_max) hp_max = s_hp;
            if (int'(s_vp) > vp_max) vp_max = s_vp;
        end
        tests_run++;
        if (fs_cnt != 5 || ls_cnt != 50) begin
            tests_failed++;
            $display("FAIL small_strobes got fs=%0d ls=%0d exp fs=5 ls=50", fs_cnt, ls_cnt);
        end
        tests_run++;
        if (vs_low != 400 || de_cnt != 720) begin
            tests_failed++;
            $display("FAIL small_regions got vs=%0d de=%0d exp vs=400 de=720", vs_low, de_cnt);
        end
        tests_run++;
        if (hp_max != 3 || vp_max != 2) begin
            tests_failed++;
            $display("FAIL small_pixel_peak got hp=%0d vp=%0d exp hp=3 vp=2", hp_max, vp_max);
        end
    endtask

    task automatic test_freeze();
        int unsigned ls_cnt = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 1201; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL freeze_idle cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
        end
        for (int i = 0; i < 3300; i++) begin
            step(1'b0, 1'b1);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL freeze_resume cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
            if (d_ls) ls_cnt++;
        end
        tests_run++;
        if (ls_cnt != 1) begin
            tests_failed++;
            $display("FAIL resume_line_starts got=%0d exp=1", ls_cnt);
        end
        for (int k = 0; k < 20; k++) begin
            int unsigned run_len = $urandom_range(1, 300);
            int unsigned hold = $urandom_range(1, 60);
            for (int i = 0; i < int'(run_len + hold); i++) begin
                step(1'b0, i < int'(run_len) ? 1'b1 : 1'b0);
                tests_run++;
                if (observed() !== predicted()) begin
                    tests_failed++;
                    $display("FAIL freeze_random cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
                end
            end
        end
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 20000; i++) begin
            step(1'b0, $urandom_range(0, 9) < 7);
            tests_run++;
            if (observed() !== predicted()) begin
                tests_failed++;
                $display("FAIL random_enable cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 5; k++) begin
            int unsigned run_len = $urandom_range(50, 1500);
            int unsigned rst_len = $urandom_range(1, 3);
            for (int i = 0; i < int'(run_len); i++) step(1'b0, 1'b1);
            for (int i = 0; i < int'(rst_len) + 500; i++) begin
                step(i < int'(rst_len) ? 1'b1 : 1'b0, $urandom_range(0, 3) != 0);
                tests_run++;
                if (observed() !== predicted()) begin
                    tests_failed++;
                    $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, observed(), predicted());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lines();
        test_frame_small();
        test_freeze();
        test_random_enable();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the HSYNC synchroniser.
- Generates both horizontal and vertical VGA timing from the FPGA system clock, using an internal pixel-tick divider.
- Produces hsync, vsync, scaled logical pixel coordinates (hpixel, vpixel), a display-enable qualifier, and line/frame start strobes.
- Sits between the clock/reset source and the pixel-memory read / colour output stage.

Parameters:
- CLK_DIV, 4: system clocks per VGA pixel (>=1).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixel ticks.
- H_SYNC, 96: horizontal sync width, in pixel ticks.
- H_BP, 48: horizontal back porch, in pixel ticks.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_SCALE, 5: VGA pixels per logical pixel horizontally; H_ACTIVE must be divisible by it.
- V_SCALE, 5: VGA lines per logical row; V_ACTIVE must be divisible by it.
- HPIX_W, 8: width of hpixel; must hold H_ACTIVE/H_SCALE-1.
- VPIX_W, 7: width of vpixel; must hold V_ACTIVE/V_SCALE-1.
- SYNC_POL, 0: active level of hsync and vsync (0 = active-low).

Ports:
- clk  in  1  system clock (100 MHz on board); single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run/freeze control.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- hpixel  out  HPIX_W  logical column, 0..H_ACTIVE/H_SCALE-1.
- vpixel  out  VPIX_W  logical row, 0..V_ACTIVE/V_SCALE-1.
- display_en  out  1  high while in the visible region.
- line_start  out  1  one-clk pulse on entry to hcnt=0.
- frame_start  out  1  one-clk pulse on entry to hcnt=0, vcnt=0.

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on the rising edge of clk.
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (has priority over enable): divider, hcnt, vcnt, hsub, vsub, hpixel, vpixel = 0; display_en, line_start, frame_start = 0; hsync, vsync = ~SYNC_POL; internal pos_new = 1.
- Divider: counts 0..CLK_DIV-1 on enabled clocks. tick = enable & (div==CLK_DIV-1). With CLK_DIV=1, tick=enable.
- On tick, hcnt advances and wraps H_TOTAL-1 -> 0. On that wrap, vcnt advances and wraps V_TOTAL-1 -> 0.
- pos_new is set on every tick and cleared on every other enabled clock.
- Regions, per axis:
  - active: [0, ACTIVE)
  - front porch: [ACTIVE, ACTIVE+FP)
  - sync: [ACTIVE+FP, ACTIVE+FP+SYNC)
  - back porch: the remainder.
- Scaling: hsub counts 0..H_SCALE-1 on ticks within the active region; when it wraps, hpixel increments.
  - hsub and hpixel clear when hcnt wraps to 0.
  - vsub/vpixel do the same per line, while vcnt is active; both clear at vcnt wrap.
  - No dividers are used.
- Outputs are a registered decode of the counter state, with 1-clk latency behind the counters:
  - hsync = SYNC_POL while hcnt is in the sync region, else ~SYNC_POL. vsync likewise on vcnt.
  - display_en = hcnt<H_ACTIVE & vcnt<V_ACTIVE.
  - hpixel/vpixel are forced to 0 when display_en would be 0.
  - line_start = pos_new & hcnt==0.
  - frame_start = line_start & vcnt==0.
  - Consequently, the first enabled clock after reset emits line_start=frame_start=1.
- enable=0: divider and all counters hold. Output registers load the idle values: display_en=0, strobes=0, pixels=0, syncs at ~SYNC_POL. pos_new holds.
- enable re-asserted: timing resumes from the frozen position. No strobe is emitted unless pos_new is still set.
- Reset asserted mid-frame: idle values appear on the next edge. Counting restarts at (0,0) once reset drops and enable=1.
- hpixel never exceeds H_ACTIVE/H_SCALE-1; vpixel never exceeds V_ACTIVE/V_SCALE-1.

Test Plan:
- Reset and idle: hold reset 10 clks, then enable=0 for 100 clks -> hsync=vsync=1, display_en=0, hpixel=vpixel=0, no strobes.
- Defaults, first line (enable=1 from clock 1 after reset): display_en=1 for clocks 2..2561; hsync=0 for clocks 2625..3008; line_start recurs every 3200 clks.
- Scaling, defaults: hpixel steps 0,1,2,… every 20 clks, peaks at 127, returns to 0 when display_en falls. vpixel steps every 5 lines and peaks at 95.
- Frame: vsync=0 for exactly 2 lines (vcnt 490-491, 6400 clks). frame_start pulses are 1,680,000 clks apart, each coincident with a line_start.
- Freeze/resume and mid-frame reset: drop enable at hcnt=300 for 50 clks -> outputs idle, hcnt holds, timing resumes with no extra strobe. Assert reset at vcnt=200 -> idle next edge, then restart at (0,0) with a frame_start.
- Parameter variant: CLK_DIV=1, H_SCALE=V_SCALE=1, SYNC_POL=1 -> line period 800 clks; hsync is high (active) for 96 clks; hpixel tracks hcnt 0..639 (with HPIX_W=10).
